// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit payload path.
// The UDP_TX_CSUM_EN build option is handled in udp_tx_payload.sv.
package udp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } tx_state_e;

  localparam int MAX_WORDS_DEF  = 512;
  localparam int ADDR_W_DEF     = 9;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 10;

  // Byte lane selection, most significant byte of the word first.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udp_csum16.sv
// Ones-complement 16-bit adder with end-around carry.
// Only instantiated when UDP_TX_CSUM_EN is defined.
module udp_csum16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);

  logic [16:0] raw;

  // A single carry fold always suffices: 0xFFFF + 0xFFFF folds to 0xFFFF.
  always_comb begin
    raw   = {1'b0, a_i} + {1'b0, b_i};
    sum_o = raw[15:0] + {15'd0, raw[16]};
  end

endmodule

// File: rtl/udp_tx_payload.sv
// Streams a payload of 32-bit RAM words out as bytes, MSB first, with ready/valid handshake.
// Define UDP_TX_CSUM_EN to compute the ones-complement payload checksum.
module udp_tx_payload
  import udp_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              E_TXC,
  input  logic              rst,
  input  logic              tx_start_i,
  input  logic [LEN_W-1:0]  tx_len_words_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [31:0]       rd_data_i,
  output logic              byte_valid_o,
  input  logic              byte_ready_i,
  output logic [7:0]        byte_data_o,
  output logic              byte_last_o,
  output logic              tx_busy_o,
  output logic              tx_done_o,
  output logic              tx_err_o,
  output logic [15:0]       payload_csum_o
);

  tx_state_e        state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] word_q, word_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      shreg_q, shreg_d;
  logic             err_q, err_d;

  logic len_ok, accept, xfer, last_word;

  assign len_ok    = (tx_len_words_i != '0) && (int'(tx_len_words_i) <= MAX_WORDS);
  assign accept    = (state_q == ST_IDLE) && tx_start_i && len_ok;
  assign xfer      = (state_q == ST_SHIFT) && byte_ready_i;
  assign last_word = (word_q == len_q - 1'b1);

  assign rd_addr_o   = ADDR_W'(word_q);
  assign byte_data_o = word_byte(shreg_q, idx_q);
  assign byte_last_o = (state_q == ST_SHIFT) && last_word && (idx_q == 2'd3);
  assign tx_busy_o   = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign tx_err_o    = err_q;

  always_ff @(posedge E_TXC or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      err_q   <= err_d;
    end
  end

  // The word counter doubles as the RAM address and never steps past the final word.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_d       = word_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    err_d        = 1'b0;
    rd_en_o      = 1'b0;
    byte_valid_o = 1'b0;
    tx_done_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_d   = tx_len_words_i;
          word_d  = '0;
          state_d = ST_FETCH;
        end else if (tx_start_i) begin
          err_d = 1'b1;
        end
      end
      ST_FETCH: begin
        rd_en_o = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_d = rd_data_i;
        idx_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        byte_valid_o = 1'b1;
        if (xfer) begin
          if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
            if (last_word) begin
              state_d = ST_DONE;
            end else begin
              word_d  = word_q + 1'b1;
              state_d = ST_FETCH;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        tx_done_o = 1'b1;
        word_d    = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef UDP_TX_CSUM_EN
  logic [15:0] csum_q, csum_d, pair, sum;

  // Big-endian pairs complete on byte lanes 1 and 3.
  assign pair = idx_q[1] ? shreg_q[15:0] : shreg_q[31:16];

  udp_csum16 u_csum (
    .a_i  (csum_q),
    .b_i  (pair),
    .sum_o(sum)
  );

  always_comb begin
    csum_d = csum_q;
    if (accept) begin
      csum_d = '0;
    end else if (xfer && idx_q[0]) begin
      csum_d = sum;
    end
  end

  always_ff @(posedge E_TXC or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign payload_csum_o = csum_q;
`else
  assign payload_csum_o = '0;
`endif

endmodule

// File: tb/tb_udp_tx_payload.sv
// Directed self-checking bench for udp_tx_payload with a synchronous payload RAM model.
module tb_udp_tx_payload;

  logic        E_TXC = 1'b0;
  logic        rst = 1'b1;
  logic        tx_start = 1'b0;
  logic [9:0]  tx_len_words = '0;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_err;
  logic [15:0] payload_csum;

  int vec_cnt = 0;
  int miss_cnt = 0;

  logic [31:0] ram [0:511];

  logic [7:0] got_bytes[$];
  logic       got_last[$];
  logic [8:0] got_addr[$];
  int done_cnt = 0, err_cnt = 0, act_cnt = 0, stall_viol = 0, last_cnt = 0;
  int cyc = 0, last_xfer_cyc = 0, done_cyc = 0;
  logic [15:0] done_csum = '0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic        prev_last = 1'b0;

  always #5 E_TXC = ~E_TXC;

  udp_tx_payload dut (
    .E_TXC         (E_TXC),
    .rst           (rst),
    .tx_start_i    (tx_start),
    .tx_len_words_i(tx_len_words),
    .rd_en_o       (rd_en),
    .rd_addr_o     (rd_addr),
    .rd_data_i     (rd_data),
    .byte_valid_o  (byte_valid),
    .byte_ready_i  (byte_ready),
    .byte_data_o   (byte_data),
    .byte_last_o   (byte_last),
    .tx_busy_o     (tx_busy),
    .tx_done_o     (tx_done),
    .tx_err_o      (tx_err),
    .payload_csum_o(payload_csum)
  );

  always @(posedge E_TXC) begin
    if (rd_en) rd_data <= ram[rd_addr];
  end

  always @(negedge E_TXC) begin
    cyc <= cyc + 1;
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!byte_valid || byte_data !== prev_data || byte_last !== prev_last))
        stall_viol <= stall_viol + 1;
      prev_stall <= byte_valid && !byte_ready;
      prev_data  <= byte_data;
      prev_last  <= byte_last;
      if (byte_valid && byte_ready) begin
        got_bytes.push_back(byte_data);
        got_last.push_back(byte_last);
        if (byte_last) begin
          last_cnt      <= last_cnt + 1;
          last_xfer_cyc <= cyc;
        end
      end
      if (rd_en) got_addr.push_back(rd_addr);
      if (tx_done) begin
        done_cnt  <= done_cnt + 1;
        done_cyc  <= cyc;
        done_csum <= payload_csum;
      end
      if (tx_err) err_cnt <= err_cnt + 1;
      if (rd_en || byte_valid || tx_busy) act_cnt <= act_cnt + 1;
    end
  end

  task automatic start_packet(input logic [9:0] len);
    @(posedge E_TXC); #1;
    tx_len_words = len;
    tx_start = 1'b1;
    @(posedge E_TXC); #1;
    tx_start = 1'b0;
  endtask

  // pattern 0: ready held high, pattern 1: ready toggles every cycle
  task automatic run_until_done(input int pattern, input int d0, input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge E_TXC); #1;
      if (pattern == 1) byte_ready = ~byte_ready;
      else byte_ready = 1'b1;
      if (done_cnt > d0) begin
        timed_out = 1'b0;
        break;
      end
    end
    byte_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge E_TXC);
    @(negedge E_TXC);
    vec_cnt++;
    if ({rd_en, byte_valid, byte_last, tx_busy, tx_done, tx_err} !== 6'b0)
      begin miss_cnt++; $display("[TB] FAIL reset_ctrl: got %b expected 000000", {rd_en, byte_valid, byte_last, tx_busy, tx_done, tx_err}); end
    vec_cnt++;
    if ({rd_addr, byte_data, payload_csum} !== 33'd0)
      begin miss_cnt++; $display("[TB] FAIL reset_data: got %h expected 0", {rd_addr, byte_data, payload_csum}); end
    @(posedge E_TXC); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int b0, a0, d0, l0;
    bit to;
    logic [31:0] word;
    logic [15:0] exp_csum;
    word = 32'h11223344;
    ram[0] = word;
    byte_ready = 1'b1;
    b0 = got_bytes.size(); a0 = got_addr.size(); d0 = done_cnt; l0 = last_cnt;
    start_packet(10'd1);
    @(negedge E_TXC);
    vec_cnt++;
    if ({rd_en, rd_addr, tx_busy, byte_valid} !== {1'b1, 9'd0, 1'b1, 1'b0})
      begin miss_cnt++; $display("[TB] FAIL single_fetch: got en=%b addr=%0d busy=%b valid=%b expected 1 0 1 0", rd_en, rd_addr, tx_busy, byte_valid); end
    @(negedge E_TXC);
    vec_cnt++;
    if ({rd_en, byte_valid} !== 2'b00)
      begin miss_cnt++; $display("[TB] FAIL single_load: got en=%b valid=%b expected 0 0", rd_en, byte_valid); end
    @(negedge E_TXC);
    vec_cnt++;
    if ({byte_valid, byte_data} !== {1'b1, 8'h11})
      begin miss_cnt++; $display("[TB] FAIL single_first_byte: got valid=%b data=%h expected 1 11", byte_valid, byte_data); end
    run_until_done(0, d0, 50, to);
    vec_cnt++;
    if (to) begin miss_cnt++; $display("[TB] FAIL single_timeout: got no tx_done expected tx_done within 50 cycles"); end
    vec_cnt++;
    if (got_bytes.size() - b0 !== 4)
      begin miss_cnt++; $display("[TB] FAIL single_count: got %0d bytes expected 4", got_bytes.size() - b0); end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (got_bytes[b0+i] !== word[31-8*i -: 8] || got_last[b0+i] !== (i == 3))
        begin miss_cnt++; $display("[TB] FAIL single_byte%0d: got %h last=%b expected %h last=%b", i, got_bytes[b0+i], got_last[b0+i], word[31-8*i -: 8], (i == 3)); end
    end
    vec_cnt++;
    if (got_addr.size() - a0 !== 1 || got_addr[a0] !== 9'd0)
      begin miss_cnt++; $display("[TB] FAIL single_reads: got %0d reads first addr %0d expected 1 read at 0", got_addr.size() - a0, got_addr[a0]); end
    vec_cnt++;
    if (done_cyc - last_xfer_cyc !== 1 || last_cnt - l0 !== 1)
      begin miss_cnt++; $display("[TB] FAIL single_done_timing: got gap %0d lasts %0d expected 1 1", done_cyc - last_xfer_cyc, last_cnt - l0); end
`ifdef UDP_TX_CSUM_EN
    exp_csum = 16'h4466;
`else
    exp_csum = 16'h0000;
`endif
    vec_cnt++;
    if (done_csum !== exp_csum)
      begin miss_cnt++; $display("[TB] FAIL single_csum: got %h expected %h", done_csum, exp_csum); end
    @(negedge E_TXC);
    vec_cnt++;
    if ({tx_busy, tx_done, rd_addr} !== 11'd0)
      begin miss_cnt++; $display("[TB] FAIL single_idle: got busy=%b done=%b addr=%0d expected 0 0 0", tx_busy, tx_done, rd_addr); end
  endtask

  task automatic test_stall();
    int b0, a0, d0, l0, s0;
    bit to;
    logic [31:0] words [3];
    logic [15:0] exp_csum;
    words[0] = 32'hDEADBEEF; words[1] = 32'h01020304; words[2] = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) ram[i] = words[i];
    b0 = got_bytes.size(); a0 = got_addr.size(); d0 = done_cnt; l0 = last_cnt; s0 = stall_viol;
    start_packet(10'd3);
    run_until_done(1, d0, 200, to);
    vec_cnt++;
    if (to) begin miss_cnt++; $display("[TB] FAIL stall_timeout: got no tx_done expected tx_done within 200 cycles"); end
    vec_cnt++;
    if (got_bytes.size() - b0 !== 12 || last_cnt - l0 !== 1)
      begin miss_cnt++; $display("[TB] FAIL stall_count: got %0d bytes %0d lasts expected 12 1", got_bytes.size() - b0, last_cnt - l0); end
    for (int i = 0; i < 12; i++) begin
      vec_cnt++;
      if (got_bytes[b0+i] !== words[i/4][31-8*(i%4) -: 8] || got_last[b0+i] !== (i == 11))
        begin miss_cnt++; $display("[TB] FAIL stall_byte%0d: got %h last=%b expected %h last=%b", i, got_bytes[b0+i], got_last[b0+i], words[i/4][31-8*(i%4) -: 8], (i == 11)); end
    end
    vec_cnt++;
    if (got_addr.size() - a0 !== 3 || got_addr[a0] !== 9'd0 || got_addr[a0+1] !== 9'd1 || got_addr[a0+2] !== 9'd2)
      begin miss_cnt++; $display("[TB] FAIL stall_addrs: got %0d reads %0d,%0d,%0d expected 3 reads 0,1,2", got_addr.size() - a0, got_addr[a0], got_addr[a0+1], got_addr[a0+2]); end
    vec_cnt++;
    if (stall_viol - s0 !== 0)
      begin miss_cnt++; $display("[TB] FAIL stall_stability: got %0d unstable stalls expected 0", stall_viol - s0); end
`ifdef UDP_TX_CSUM_EN
    exp_csum = 16'hECEE;
`else
    exp_csum = 16'h0000;
`endif
    vec_cnt++;
    if (done_csum !== exp_csum)
      begin miss_cnt++; $display("[TB] FAIL stall_csum: got %h expected %h", done_csum, exp_csum); end
  endtask

  task automatic test_reject();
    int e0, act0;
    e0 = err_cnt; act0 = act_cnt;
    start_packet(10'd0);
    @(negedge E_TXC);
    vec_cnt++;
    if (tx_err !== 1'b1) begin miss_cnt++; $display("[TB] FAIL reject_len0_pulse: got tx_err=%b expected 1", tx_err); end
    @(negedge E_TXC);
    vec_cnt++;
    if (tx_err !== 1'b0) begin miss_cnt++; $display("[TB] FAIL reject_len0_width: got tx_err=%b expected 0", tx_err); end
    start_packet(10'd513);
    repeat (4) @(posedge E_TXC);
    #1;
    vec_cnt++;
    if (err_cnt - e0 !== 2)
      begin miss_cnt++; $display("[TB] FAIL reject_errs: got %0d tx_err cycles expected 2", err_cnt - e0); end
    vec_cnt++;
    if (act_cnt - act0 !== 0)
      begin miss_cnt++; $display("[TB] FAIL reject_activity: got %0d active cycles expected 0", act_cnt - act0); end
  endtask

  task automatic test_back_to_back();
    int b0, a0, d0, l0, e0;
    bit to;
    for (int i = 0; i < 4; i++) ram[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    b0 = got_bytes.size(); a0 = got_addr.size(); d0 = done_cnt; l0 = last_cnt; e0 = err_cnt;
    byte_ready = 1'b1;
    start_packet(10'd4);
    repeat (5) @(posedge E_TXC);
    #1;
    tx_len_words = 10'd2;
    tx_start = 1'b1;
    @(posedge E_TXC); #1;
    tx_start = 1'b0;
    run_until_done(0, d0, 200, to);
    repeat (20) @(posedge E_TXC);
    #1;
    vec_cnt++;
    if (to) begin miss_cnt++; $display("[TB] FAIL b2b_timeout: got no tx_done expected tx_done within 200 cycles"); end
    vec_cnt++;
    if (got_bytes.size() - b0 !== 16 || done_cnt - d0 !== 1 || err_cnt - e0 !== 0)
      begin miss_cnt++; $display("[TB] FAIL b2b_counts: got %0d bytes %0d dones %0d errs expected 16 1 0", got_bytes.size() - b0, done_cnt - d0, err_cnt - e0); end
    for (int i = 0; i < 16; i++) begin
      vec_cnt++;
      if (got_bytes[b0+i] !== 8'(i) || got_last[b0+i] !== (i == 15))
        begin miss_cnt++; $display("[TB] FAIL b2b_byte%0d: got %h last=%b expected %h last=%b", i, got_bytes[b0+i], got_last[b0+i], 8'(i), (i == 15)); end
    end
    vec_cnt++;
    if (got_addr.size() - a0 !== 4 || got_addr[a0+3] !== 9'd3 || last_cnt - l0 !== 1)
      begin miss_cnt++; $display("[TB] FAIL b2b_reads: got %0d reads last addr %0d lasts %0d expected 4 3 1", got_addr.size() - a0, got_addr[a0+3], last_cnt - l0); end
  endtask

  task automatic test_reset_mid();
    int b0, a0, d0, l0;
    bit to;
    bit reached;
    for (int i = 0; i < 4; i++) ram[i] = 32'h55AA55AA ^ i;
    b0 = got_bytes.size(); d0 = done_cnt; l0 = last_cnt;
    byte_ready = 1'b1;
    start_packet(10'd4);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge E_TXC); #1;
      if (got_bytes.size() - b0 >= 6) begin
        reached = 1'b1;
        break;
      end
    end
    vec_cnt++;
    if (!reached) begin miss_cnt++; $display("[TB] FAIL rstmid_progress: got %0d bytes expected 6", got_bytes.size() - b0); end
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({rd_en, byte_valid, byte_last, tx_busy, tx_done, tx_err, rd_addr, byte_data, payload_csum} !== 39'd0)
      begin miss_cnt++; $display("[TB] FAIL rstmid_async: got %h expected 0", {rd_en, byte_valid, byte_last, tx_busy, tx_done, tx_err, rd_addr, byte_data, payload_csum}); end
    repeat (3) @(posedge E_TXC);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge E_TXC);
    #1;
    vec_cnt++;
    if (done_cnt - d0 !== 0 || last_cnt - l0 !== 0)
      begin miss_cnt++; $display("[TB] FAIL rstmid_abandon: got %0d dones %0d lasts expected 0 0", done_cnt - d0, last_cnt - l0); end
    ram[0] = 32'hCAFEF00D;
    b0 = got_bytes.size(); a0 = got_addr.size(); d0 = done_cnt;
    start_packet(10'd1);
    run_until_done(0, d0, 50, to);
    vec_cnt++;
    if (to || got_addr.size() - a0 !== 1 || got_addr[a0] !== 9'd0)
      begin miss_cnt++; $display("[TB] FAIL rstmid_restart: got timeout=%b reads=%0d addr=%0d expected 0 1 0", to, got_addr.size() - a0, got_addr[a0]); end
    vec_cnt++;
    if ({got_bytes[b0], got_bytes[b0+1], got_bytes[b0+2], got_bytes[b0+3]} !== 32'hCAFEF00D || got_bytes.size() - b0 !== 4)
      begin miss_cnt++; $display("[TB] FAIL rstmid_bytes: got %h%h%h%h (%0d) expected CAFEF00D (4)", got_bytes[b0], got_bytes[b0+1], got_bytes[b0+2], got_bytes[b0+3], got_bytes.size() - b0); end
  endtask

  task automatic test_csum();
    int d0;
    bit to;
    logic [15:0] exp_csum;
    ram[0] = 32'hFFFF0001;
    d0 = done_cnt;
    start_packet(10'd1);
    run_until_done(0, d0, 50, to);
`ifdef UDP_TX_CSUM_EN
    exp_csum = 16'h0001;
`else
    exp_csum = 16'h0000;
`endif
    vec_cnt++;
    if (to || done_csum !== exp_csum)
      begin miss_cnt++; $display("[TB] FAIL csum_done: got timeout=%b csum=%h expected 0 %h", to, done_csum, exp_csum); end
    repeat (4) @(posedge E_TXC);
    @(negedge E_TXC);
    vec_cnt++;
    if (payload_csum !== exp_csum)
      begin miss_cnt++; $display("[TB] FAIL csum_hold: got %h expected %h", payload_csum, exp_csum); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = '0;
    test_reset();
    test_single();
    test_stall();
    test_reject();
    test_back_to_back();
    test_reset_mid();
    test_csum();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/udp_tx_payload.md
UDP_TX_PAYLOAD -- requirements
Module: udp_tx_payload

Interface
REQ-001 Parameter ADDR_W, default 9, word-address width of the payload RAM read port.
REQ-002 Parameter MAX_WORDS, default 512, largest legal packet length in 32-bit words.
REQ-003 E_TXC  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 tx_start  input  1  one-cycle request to send a payload.
REQ-006 tx_len_words  input  10  payload length in words, sampled with tx_start.
REQ-007 rd_en  output  1  payload RAM read enable.
REQ-008 rd_addr  output  ADDR_W  payload RAM word address.
REQ-009 rd_data  input  32  RAM data, valid the cycle after rd_en.
REQ-010 byte_valid  output  1  byte_data holds a valid payload byte.
REQ-011 byte_ready  input  1  UDP transmitter accepts the byte this cycle.
REQ-012 byte_data  output  8  payload byte.
REQ-013 byte_last  output  1  final byte of the packet, qualified by byte_valid.
REQ-014 tx_busy  output  1  packet in progress.
REQ-015 tx_done  output  1  one-cycle pulse after the last byte is accepted.
REQ-016 tx_err  output  1  one-cycle pulse on a rejected tx_start.
REQ-017 payload_csum  output  16  ones-complement payload sum, valid with tx_done.

Function
REQ-018 FSM states: IDLE, FETCH, LOAD, SHIFT, DONE.
REQ-019 IDLE + tx_start + 1<=tx_len_words<=MAX_WORDS -> latch the length, set rd_addr=0 and tx_busy=1, then go to FETCH.
REQ-020 IDLE + tx_start with a length of 0 or >MAX_WORDS -> tx_err=1 for one cycle, stay in IDLE, no RAM read.
REQ-021 FETCH: rd_en=1 for exactly one cycle -> LOAD.
REQ-022 LOAD: capture rd_data into the 32-bit shift register, byte index=0 -> SHIFT.
REQ-023 SHIFT: byte_data = current byte, MSB first (bits 31:24 first); byte_valid=1.
REQ-024 byte_data, byte_last and byte_valid hold stable until byte_ready=1; byte_valid never drops without a transfer.
REQ-025 Transfer on the 4th byte of a non-final word -> rd_addr+1, go to FETCH; on the 4th byte of the final word -> DONE.
REQ-026 byte_last=1 only on byte 3 of word (len-1).
REQ-027 DONE: tx_done=1 for one cycle, tx_busy=0 -> IDLE; rd_addr returns to 0.
REQ-028 tx_start while tx_busy=1 is ignored, with no tx_err and no length change.
REQ-029 byte_ready while byte_valid=0 has no effect.
REQ-030 Latency: first byte_valid 3 cycles after the tx_start edge; each word costs 2 idle cycles plus 4 transfer beats.
REQ-031 rd_addr never exceeds len-1; when len=MAX_WORDS the address counter does not wrap before DONE.

Reset
REQ-032 rst=1 forces IDLE immediately; every output is 0; the shift register, the length and the checksum are 0.
REQ-033 rst during a packet abandons it: no tx_done and no byte_last are issued; a new tx_start after release is served from address 0.

Configuration
REQ-034 Macro UDP_TX_CSUM_EN defined: accumulate the 16-bit big-endian byte pairs of the payload into a ones-complement sum with end-around carry, cleared on the accepted tx_start; payload_csum = final sum, held from tx_done until the next accepted tx_start.
REQ-035 UDP_TX_CSUM_EN undefined: no accumulator logic; payload_csum tied to 0.

Structure
REQ-036 Shared package udp_pkg holds: the FSM state enum, MAX_WORDS_DEF=512, ADDR_W_DEF=9, and the byte-lane constant BYTES_PER_WORD=4.
REQ-037 Optional sub-module udp_csum16 (ones-complement 16-bit adder with end-around carry), instantiated only under UDP_TX_CSUM_EN.

Verification
REQ-038 RAM word 0 = 32'h11223344, len=1, byte_ready held 1 -> bytes 11,22,33,44; byte_last on 44; tx_done one cycle later; rd_en asserted once, at addr 0.
REQ-039 len=3, RAM={DEADBEEF,01020304,A5A5A5A5}, byte_ready toggling 1/0 -> 12 bytes in order; each byte stable across the stalls; rd_addr 0,1,2.
REQ-040 tx_start with len=0, then with len=513 -> two tx_err pulses; rd_en, byte_valid and tx_busy stay 0.
REQ-041 Second tx_start during a len=4 packet -> ignored; exactly 16 bytes and one tx_done.
REQ-042 rst asserted after the 6th byte of a len=4 packet -> all outputs 0 asynchronously; after release, len=1 with RAM[0]=CAFEF00D -> CA,FE,F0,0D.
REQ-043 UDP_TX_CSUM_EN defined, payload {FFFF0001} -> payload_csum = 16'h0001 at tx_done; macro undefined -> payload_csum = 0.
